spi_tx_fifo: RTL and testbench

Synchronous first-word-fall-through (FWFT) word buffer between the AXI write-data path and the SPI master's transmit input inside `axi_spi_if`. It stores whole serial words of `g_word_length` bits and presents the head word combinationally to the SPI master. It reports fill level, full, almost-full and empty. Sticky overflow and underflow flags record handshake violations for the AXI status register.

---
 rtl/spi_tx_fifo_if.sv | 29 ++
 rtl/spi_tx_fifo.sv | 78 +++++++
 tb/tb_spi_tx_fifo.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_tx_fifo_if.sv
// Bus bundle between the AXI write-data path (master) and the SPI transmit FIFO (slave).
// Handshake: wr_en_i/rd_en_i are single-cycle requests sampled on each rising edge; a write
// is taken when !full_o or a read is taken in the same cycle, a read is taken when !empty_o;
// a request that is not taken is dropped (never held) and raises the sticky ovf_o/udf_o.
interface spi_tx_fifo_if #(
  parameter int g_word_length = 32,
  parameter int g_depth_log2  = 4
);
  logic                     wr_en_i;
  logic [g_word_length-1:0] wr_data_i;
  logic                     full_o;
  logic                     almost_full_o;
  logic                     rd_en_i;
  logic [g_word_length-1:0] rd_data_o;
  logic                     empty_o;
  logic [g_depth_log2:0]    level_o;
  logic                     ovf_o;
  logic                     udf_o;

  modport master (
    output wr_en_i, wr_data_i, rd_en_i,
    input  full_o, almost_full_o, rd_data_o, empty_o, level_o, ovf_o, udf_o
  );

  modport slave (
    input  wr_en_i, wr_data_i, rd_en_i,
    output full_o, almost_full_o, rd_data_o, empty_o, level_o, ovf_o, udf_o
  );
endinterface

// File: rtl/spi_tx_fifo.sv
// First-word-fall-through word buffer feeding the SPI master transmit path, with level,
// full/almost-full/empty status and sticky overflow/underflow flags.
module spi_tx_fifo #(
  parameter int g_word_length = 32,
  parameter int g_depth_log2  = 4,
  parameter int g_afull_level = 14
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          clr_i,
  spi_tx_fifo_if.slave bus
);
  localparam logic [g_depth_log2:0]   c_depth   = {1'b1, {g_depth_log2{1'b0}}};
  localparam logic [g_depth_log2:0]   c_afull   = (g_depth_log2 + 1)'(g_afull_level);
  localparam logic [g_depth_log2-1:0] c_ptr_one = (g_depth_log2)'(1);
  localparam logic [g_depth_log2:0]   c_lvl_one = (g_depth_log2 + 1)'(1);

  logic [g_word_length-1:0] mem [1 << g_depth_log2];
  logic [g_depth_log2-1:0]  wr_ptr;
  logic [g_depth_log2-1:0]  rd_ptr;
  logic [g_depth_log2:0]    level;
  logic                     ovf;
  logic                     udf;
  logic                     empty;
  logic                     full;
  logic                     wr_acc;
  logic                     rd_acc;
  logic                     wr_rej;
  logic                     rd_rej;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a concurrent write.
  always_comb begin
    empty  = (level == '0);
    full   = (level == c_depth);
    rd_acc = bus.rd_en_i & ~empty;
    wr_acc = bus.wr_en_i & (~full | rd_acc);
    wr_rej = bus.wr_en_i & ~wr_acc;
    rd_rej = bus.rd_en_i & empty;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + c_ptr_one;
      if (rd_acc) rd_ptr <= rd_ptr + c_ptr_one;
      if (wr_acc && !rd_acc)      level <= level + c_lvl_one;
      else if (rd_acc && !wr_acc) level <= level - c_lvl_one;
      if (wr_rej) ovf <= 1'b1;
      if (rd_rej) udf <= 1'b1;
    end
  end

  // Storage carries no reset; an empty level already hides stale words from the output.
  always_ff @(posedge clk_i) begin
    if (!clr_i && wr_acc) mem[wr_ptr] <= bus.wr_data_i;
  end

  always_comb begin
    bus.level_o       = level;
    bus.empty_o       = empty;
    bus.full_o        = full;
    bus.almost_full_o = (level >= c_afull);
    bus.ovf_o         = ovf;
    bus.udf_o         = udf;
    bus.rd_data_o     = empty ? '0 : mem[rd_ptr];
  end
endmodule

// File: tb/tb_spi_tx_fifo.sv
// Self-checking bench for spi_tx_fifo: directed vector table, boundary sequences, and
// randomized traffic checked against a queue-based reference model.
module tb_spi_tx_fifo;
  localparam int W     = 32;
  localparam int LG    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;

  typedef struct {
    logic          wr;
    logic          rd;
    logic          clr;
    logic [W-1:0]  data;
    logic [LG:0]   lvl;
    logic          empty;
    logic          full;
    logic          afull;
    logic          ovf;
    logic          udf;
    logic [W-1:0]  rdata;
  } vec_t;

  logic clk_i;
  logic rst_i;
  logic clr_i;

  spi_tx_fifo_if #(.g_word_length(W), .g_depth_log2(LG)) bus ();

  spi_tx_fifo #(
    .g_word_length(W),
    .g_depth_log2 (LG),
    .g_afull_level(AF)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(clr_i),
    .bus  (bus)
  );

  int           total;
  int           bad;
  logic [W-1:0] exp_q[$];
  logic         exp_ovf;
  logic         exp_udf;
  vec_t         vecs[13];

  // ---------------- clock / watchdog ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic wr, input logic rd, input logic clr,
                            input logic [W-1:0] data);
    logic rd_ok;
    logic wr_ok;
    if (clr) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      rd_ok = rd && (exp_q.size() > 0);
      wr_ok = wr && ((exp_q.size() < DEPTH) || rd_ok);
      if (rd && !rd_ok) exp_udf = 1'b1;
      if (wr && !wr_ok) exp_ovf = 1'b1;
      if (rd_ok) void'(exp_q.pop_front());
      if (wr_ok) exp_q.push_back(data);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = exp_q.size();
    check({tag, " level"}, W'(bus.level_o), W'(n));
    check({tag, " empty"}, W'(bus.empty_o), W'(n == 0));
    check({tag, " full"},  W'(bus.full_o),  W'(n == DEPTH));
    check({tag, " afull"}, W'(bus.almost_full_o), W'(n >= AF));
    check({tag, " ovf"},   W'(bus.ovf_o), W'(exp_ovf));
    check({tag, " udf"},   W'(bus.udf_o), W'(exp_udf));
    check({tag, " rdata"}, bus.rd_data_o, (n > 0) ? exp_q[0] : '0);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic wr, input logic rd, input logic clr, input logic [W-1:0] data);
    bus.wr_en_i   = wr;
    bus.rd_en_i   = rd;
    bus.wr_data_i = data;
    clr_i         = clr;
    @(posedge clk_i);
    #1;
    model_step(wr, rd, clr, data);
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    clr_i       = 1'b0;
  endtask

  function automatic vec_t mk(input int wr, input int rd, input int clr, input logic [W-1:0] data,
                              input int lvl, input int empty, input int full, input int afull,
                              input int ovf, input int udf, input logic [W-1:0] rdata);
    vec_t v;
    v.wr = (wr != 0);   v.rd = (rd != 0);   v.clr = (clr != 0);  v.data = data;
    v.lvl = (LG + 1)'(lvl);
    v.empty = (empty != 0); v.full = (full != 0); v.afull = (afull != 0);
    v.ovf = (ovf != 0); v.udf = (udf != 0); v.rdata = rdata;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    int bias;
    total = 0;
    bad = 0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    rst_i = 1'b0;
    clr_i = 1'b0;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.wr_data_i = '0;

    //           wr rd clr data            lvl e f af ov ud rdata
    vecs[0]  = mk(1, 0, 0, 32'hA5A5_0001, 1, 0, 0, 0, 0, 0, 32'hA5A5_0001);
    vecs[1]  = mk(0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 0, 32'h0);
    vecs[2]  = mk(1, 1, 0, 32'h55,        1, 0, 0, 0, 0, 1, 32'h55);
    vecs[3]  = mk(0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 1, 32'h0);
    vecs[4]  = mk(0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 1, 32'h0);
    vecs[5]  = mk(0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 1, 32'h0);
    vecs[6]  = mk(0, 0, 1, 32'h0,         0, 1, 0, 0, 0, 0, 32'h0);
    vecs[7]  = mk(0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 1, 32'h0);
    vecs[8]  = mk(0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 1, 32'h0);
    vecs[9]  = mk(0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 1, 32'h0);
    vecs[10] = mk(1, 0, 0, 32'h1,         1, 0, 0, 0, 0, 1, 32'h1);
    vecs[11] = mk(0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 1, 32'h0);
    vecs[12] = mk(0, 0, 1, 32'h0,         0, 1, 0, 0, 0, 0, 32'h0);

    // Reset values while rst_i is held low
    #12;
    check("reset level", W'(bus.level_o), W'(0));
    check("reset empty", W'(bus.empty_o), W'(1));
    check("reset full",  W'(bus.full_o),  W'(0));
    check("reset afull", W'(bus.almost_full_o), W'(0));
    check("reset ovf",   W'(bus.ovf_o), W'(0));
    check("reset udf",   W'(bus.udf_o), W'(0));
    check("reset rdata", bus.rd_data_o, W'(0));
    rst_i = 1'b1;

    // Directed vector table: FWFT, empty read+write, underflow, clear
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].data);
      check($sformatf("vec%0d level", i), W'(bus.level_o), W'(vecs[i].lvl));
      check($sformatf("vec%0d empty", i), W'(bus.empty_o), W'(vecs[i].empty));
      check($sformatf("vec%0d full", i),  W'(bus.full_o),  W'(vecs[i].full));
      check($sformatf("vec%0d afull", i), W'(bus.almost_full_o), W'(vecs[i].afull));
      check($sformatf("vec%0d ovf", i),   W'(bus.ovf_o), W'(vecs[i].ovf));
      check($sformatf("vec%0d udf", i),   W'(bus.udf_o), W'(vecs[i].udf));
      check($sformatf("vec%0d rdata", i), bus.rd_data_o, vecs[i].rdata);
    end

    // Fill to full, simultaneous access at full, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, W'(i));
      check("fill level", W'(bus.level_o), W'(i + 1));
      check("fill afull", W'(bus.almost_full_o), W'((i + 1) >= AF));
      check("fill full",  W'(bus.full_o), W'((i + 1) == DEPTH));
      check("fill head",  bus.rd_data_o, W'(0));
    end
    step(1'b1, 1'b1, 1'b0, 32'h77);
    check("full rw level", W'(bus.level_o), W'(DEPTH));
    check("full rw ovf",   W'(bus.ovf_o), W'(0));
    check("full rw head",  bus.rd_data_o, W'(1));
    step(1'b1, 1'b0, 1'b0, 32'hDEAD);
    check("ovf flag",  W'(bus.ovf_o), W'(1));
    check("ovf level", W'(bus.level_o), W'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      check("drain order", bus.rd_data_o, (i < DEPTH - 1) ? W'(i + 1) : 32'h77);
      step(1'b0, 1'b1, 1'b0, '0);
    end
    check("drain empty", W'(bus.empty_o), W'(1));
    check("drain rdata", bus.rd_data_o, W'(0));

    // Pointer wrap with interleaved traffic
    step(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, W'(32'h100 + i));
    for (int i = 0; i < 24; i++) begin
      step(1'b1, (i % 3) != 2, 1'b0, W'(32'h200 + i));
      check_model("wrap");
    end
    while (exp_q.size() > 0) begin
      step(1'b0, 1'b1, 1'b0, '0);
      check_model("wrap drain");
    end

    // Clear at level 5 with ovf set, together with a write
    step(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, W'(32'h300 + i));
    step(1'b1, 1'b0, 1'b0, 32'hDEAD);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("pre-clr level", W'(bus.level_o), W'(5));
    check("pre-clr ovf",   W'(bus.ovf_o), W'(1));
    step(1'b1, 1'b0, 1'b1, 32'hBEEF);
    check("clr level", W'(bus.level_o), W'(0));
    check("clr empty", W'(bus.empty_o), W'(1));
    check("clr ovf",   W'(bus.ovf_o), W'(0));
    check("clr rdata", bus.rd_data_o, W'(0));

    // Randomized traffic against the reference model
    for (int p = 0; p < 4; p++) begin
      bias = (p == 0) ? 80 : (p == 1) ? 20 : (p == 2) ? 65 : 50;
      for (int c = 0; c < 120; c++) begin
        step($urandom_range(99) < bias, $urandom_range(99) >= bias,
             $urandom_range(149) == 0, $urandom);
        check_model("rand");
      end
    end

    // Asynchronous reset between clock edges
    step(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, W'(32'h400 + i));
    check("pre-rst level", W'(bus.level_o), W'(9));
    #3;
    rst_i = 1'b0;
    #1;
    check("async rst level", W'(bus.level_o), W'(0));
    check("async rst empty", W'(bus.empty_o), W'(1));
    check("async rst rdata", bus.rd_data_o, W'(0));
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    #2;
    rst_i = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h1234);
    check_model("post-rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
